// File: rtl/sba_ram_responder.sv
// Purpose: word-organised scratch RAM acting as responder on the req/gnt/rvalid system bus.
// Latency: grant in cycle T gives a one-cycle rvalid_o in cycle T+1+WAIT_CYCLES.
// Backpressure: one transaction outstanding; gnt_o is withheld until the response has been issued.
module sba_ram_responder #(
   parameter int          DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
   parameter int          WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [32:0] SPAN     = 33'(DEPTH) * 33'd4;
   localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   localparam logic [2:0] S_IDLE = 3'b001;
   localparam logic [2:0] S_WAIT = 3'b010;
   localparam logic [2:0] S_RESP = 3'b100;

   logic [2:0]  state;
   logic [3:0]  cnt;

   logic        we_q;
   logic [3:0]  be_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   logic        exec_en;
   logic        exec_we;
   logic [3:0]  exec_be;
   logic [31:0] exec_addr;
   logic [31:0] exec_wdata;
   logic [31:0] offset;
   logic        in_range;
   logic [AW-1:0] idx;
   logic        mem_we;

   logic [31:0] mem [DEPTH];

   assign gnt_o = req_i && (state == S_IDLE);

   // Select the access to execute: live bus inputs when there is no wait, else the captured request.
   always_comb begin
      exec_en    = 1'b0;
      exec_we    = we_q;
      exec_be    = be_q;
      exec_addr  = addr_q;
      exec_wdata = wdata_q;
      if (WAIT_CYCLES == 0) begin
         exec_en    = gnt_o;
         exec_we    = we_i;
         exec_be    = be_i;
         exec_addr  = addr_i;
         exec_wdata = wdata_i;
      end else begin
         exec_en = (state == S_WAIT) && (cnt == 4'd0);
      end
   end

   // Offset from the base wraps for addresses below BASE_ADDR, so one unsigned compare covers both bounds.
   assign offset   = exec_addr - BASE_ADDR;
   assign in_range = ({1'b0, offset} < SPAN);
   assign idx      = offset[AW+1:2];
   // Gated by rst_n so a request seen while reset is held can never commit.
   assign mem_we   = exec_en && exec_we && in_range && rst_n;

   // Byte-lane write into the array; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int k = 0; k < 4; k++) begin
            if (exec_be[k]) begin
               mem[idx][8*k +: 8] <= exec_wdata[8*k +: 8];
            end
         end
      end
   end

   // Transaction sequencing: capture on grant, count wait cycles, then hold S_RESP for one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         we_q    <= 1'b0;
         be_q    <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (gnt_o) begin
                  we_q    <= we_i;
                  be_q    <= be_i;
                  addr_q  <= addr_i;
                  wdata_q <= wdata_i;
                  if (WAIT_CYCLES == 0) begin
                     state <= S_RESP;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= CNT_LOAD;
                  end
               end
            end
            S_WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state <= S_RESP;
               end
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Response registers: loaded on the execute edge, cleared after the single response cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_o <= 1'b0;
         rdata_o  <= 32'd0;
         err_o    <= 1'b0;
      end else if (exec_en) begin
         rvalid_o <= 1'b1;
         err_o    <= !in_range;
         rdata_o  <= (in_range && !exec_we) ? mem[idx] : 32'd0;
      end else if (rvalid_o) begin
         rvalid_o <= 1'b0;
         rdata_o  <= 32'd0;
         err_o    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sba_ram_responder.sv
// Purpose: directed and randomized checks of sba_ram_responder at WAIT_CYCLES of 0, 3 and 2.
// Latency: expected response cycle is T+1+WAIT_CYCLES for a grant in cycle T.
// Backpressure: request is held until the response to observe that no grant is given while busy.
module tb_sba_ram_responder;

   localparam int          DEPTH = 64;
   localparam logic [31:0] BASE  = 32'h2000_0000;

   logic        clk;
   logic        rst_n;
   logic        req   [3];
   logic        gnt   [3];
   logic        we    [3];
   logic [3:0]  be    [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic        rvalid[3];
   logic [31:0] rdata [3];
   logic        err   [3];

   logic [31:0] model [3][DEPTH];

   int passed = 0;
   int total  = 0;

   sba_ram_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .rst_n(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .we_i(we[0]), .be_i(be[0]),
      .addr_i(addr[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));

   sba_ram_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .rst_n(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .we_i(we[1]), .be_i(be[1]),
      .addr_i(addr[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));

   sba_ram_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) u_w2 (
      .clk(clk), .rst_n(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .we_i(we[2]), .be_i(be[2]),
      .addr_i(addr[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wc(input int d);
      case (d)
         0:       return 0;
         1:       return 3;
         default: return 2;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Reference behaviour: plain range arithmetic and byte merging on a word array.
   function automatic void ref_exec(input int d, input logic w, input logic [3:0] b,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    output logic [31:0] er, output logic ee);
      longint la = longint'(a);
      longint lb = longint'(BASE);
      int     i;
      er = 32'd0;
      ee = 1'b1;
      if (la >= lb && la < lb + 4 * DEPTH) begin
         i  = int'((la - lb) / 4);
         ee = 1'b0;
         if (w) begin
            for (int k = 0; k < 4; k++)
               if (b[k]) model[d][i][8*k +: 8] = wd[8*k +: 8];
         end else begin
            er = model[d][i];
         end
      end
   endfunction

   // One bus transaction with request held until the response; chg perturbs inputs after the grant edge.
   task automatic txn(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] wd, input bit chg);
      logic [31:0] er;
      logic        ee;
      int          n;
      int          lat;
      @(negedge clk);
      chk("idle_rvalid", {31'd0, rvalid[d]}, 32'd0);
      chk("idle_rdata", rdata[d], 32'd0);
      chk("idle_err", {31'd0, err[d]}, 32'd0);
      we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd; req[d] = 1'b1;
      #1;
      chk("gnt_immediate", {31'd0, gnt[d]}, 32'd1);
      n = 0;
      while (gnt[d] !== 1'b1 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 20) begin
         chk("gnt_timeout", 32'(n), 32'd0);
         req[d] = 1'b0;
         return;
      end
      ref_exec(d, w, b, a, wd, er, ee);
      @(negedge clk);
      lat = 1;
      if (chg) begin
         addr[d]  = a ^ 32'h4;
         wdata[d] = ~wd;
         be[d]    = 4'hF;
      end
      while (rvalid[d] !== 1'b1 && lat < 40) begin
         chk("gnt_busy", {31'd0, gnt[d]}, 32'd0);
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'(1 + wc(d)));
      chk("gnt_resp", {31'd0, gnt[d]}, 32'd0);
      chk("rdata", rdata[d], er);
      chk("err", {31'd0, err[d]}, {31'd0, ee});
      req[d] = 1'b0;
   endtask

   initial begin
      logic [31:0] old5;
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'd0; addr[d] = 32'd0; wdata[d] = 32'd0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk("rst_gnt", {31'd0, gnt[d]}, 32'd0);
         chk("rst_rvalid", {31'd0, rvalid[d]}, 32'd0);
         chk("rst_rdata", rdata[d], 32'd0);
         chk("rst_err", {31'd0, err[d]}, 32'd0);
      end
      rst_n = 1'b1;

      // Give every word a known value so later reads have defined expectations.
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < DEPTH; i++)
            txn(d, 1'b1, 4'hF, BASE + 32'(4 * i), $urandom, 1'b0);

      // Full write then read, zero wait states.
      txn(0, 1'b1, 4'hF, 32'h2000_0010, 32'hDEAD_BEEF, 1'b0);
      txn(0, 1'b0, 4'hF, 32'h2000_0010, 32'h0, 1'b0);
      // Single byte lane update, then empty byte enable.
      txn(0, 1'b1, 4'b0100, 32'h2000_0010, 32'h0055_0000, 1'b0);
      txn(0, 1'b0, 4'h0, 32'h2000_0010, 32'h0, 1'b0);
      chk("byte_lane_word", model[0][4], 32'hDE55_BEEF);
      txn(0, 1'b1, 4'h0, 32'h2000_0010, 32'h1234_5678, 1'b0);
      txn(0, 1'b0, 4'hF, 32'h2000_0010, 32'h0, 1'b0);

      // Three wait states with request held: latency, busy grant and next-grant timing.
      txn(1, 1'b0, 4'hF, BASE + 32'd20, 32'h0, 1'b0);
      txn(1, 1'b0, 4'h3, BASE + 32'd24, 32'h0, 1'b0);

      // Out-of-range below base and just past the top, then boundary words.
      txn(0, 1'b1, 4'hF, 32'h1FFF_FFFC, 32'hAAAA_5555, 1'b0);
      txn(0, 1'b0, 4'hF, 32'h1FFF_FFFC, 32'h0, 1'b0);
      txn(0, 1'b1, 4'hF, BASE + 32'(4 * DEPTH), 32'h5555_AAAA, 1'b0);
      txn(0, 1'b0, 4'hF, BASE + 32'(4 * DEPTH), 32'h0, 1'b0);
      txn(0, 1'b0, 4'hF, BASE, 32'h0, 1'b0);
      txn(0, 1'b0, 4'hF, BASE + 32'(4 * (DEPTH - 1)), 32'h0, 1'b0);

      // Reset two cycles after grant of a write to word 5: nothing commits, no response.
      old5 = model[1][5];
      @(negedge clk);
      we[1] = 1'b1; be[1] = 4'hF; addr[1] = BASE + 32'd20; wdata[1] = ~old5; req[1] = 1'b1;
      #1;
      chk("rst_mid_gnt", {31'd0, gnt[1]}, 32'd1);
      @(negedge clk);
      req[1] = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_rvalid", {31'd0, rvalid[1]}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("rst_no_rvalid", {31'd0, rvalid[1]}, 32'd0);
      end
      txn(1, 1'b0, 4'hF, BASE + 32'd20, 32'h0, 1'b0);

      // Inputs changed after the grant edge must not leak into the access.
      txn(2, 1'b1, 4'hF, BASE + 32'd40, 32'hCAFE_0001, 1'b1);
      txn(2, 1'b0, 4'hF, BASE + 32'd40, 32'h0, 1'b0);
      txn(2, 1'b0, 4'hF, BASE + 32'd44, 32'h0, 1'b0);

      // Randomized traffic over all three instances, including out-of-range and unaligned addresses.
      for (int t = 0; t < 60; t++) begin
         int          d;
         int          r;
         logic [31:0] a;
         d = int'($urandom_range(0, 2));
         r = int'($urandom_range(0, 7));
         if (r == 0)      a = BASE - 32'(4 * $urandom_range(1, 4));
         else if (r == 1) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
         else             a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
         txn(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, 1'b0);
      end

      // Final sweep of a few words per instance against the model.
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < DEPTH; i += 9)
            txn(d, 1'b0, 4'hF, BASE + 32'(4 * i), 32'h0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/sba_ram_responder.md
# sba_ram_responder

Single-port, word-organised RAM that acts as the responder on the req/gnt/rvalid system bus driven by the debug system-bus-access initiator and core masters. It accepts one transaction at a time, inserts a programmable number of wait cycles, and applies byte-enabled writes or returns full-word reads. Each transaction ends with a single-cycle `rvalid_o`, and out-of-range addresses are flagged on `err_o`. It sits behind the bus interconnect as a debug-visible scratch and data memory.

## Interface
- `DEPTH`, 1024: number of 32-bit words; power of two, ≥ 2.
- `BASE_ADDR`, 32'h2000_0000: byte address of word 0; aligned to `4*DEPTH`.
- `WAIT_CYCLES`, 0: extra cycles between grant and response, 0..15.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  initiator request; held until `gnt_o`.
- `gnt_o`  out  1  grant; combinational.
- `we_i`  in  1  1 = write, 0 = read; valid with `req_i`.
- `be_i`  in  4  byte enables; valid with `req_i`.
- `addr_i`  in  32  byte address; valid with `req_i`.
- `wdata_i`  in  32  write data; valid with `req_i`.
- `rvalid_o`  out  1  response strobe, one cycle per granted transaction (reads and writes).
- `rdata_o`  out  32  read data; valid only while `rvalid_o`=1.
- `err_o`  out  1  error flag; valid only while `rvalid_o`=1.

## Operation
- States are one-hot: S_IDLE, S_WAIT, S_RESP. Reset state is S_IDLE.
- `gnt_o = req_i && (state == S_IDLE)`. Only one transaction is outstanding at a time. No grant is issued in S_WAIT or S_RESP.
- On the grant edge, the block registers `we_i`, `be_i`, `addr_i` and `wdata_i`.
  - If `WAIT_CYCLES`=0: the access executes at this edge, then the state goes to S_RESP.
  - Otherwise: the state goes to S_WAIT and the counter loads `WAIT_CYCLES-1`.
- In S_WAIT:
  - If counter ≠ 0: the counter decrements.
  - If counter = 0: the access executes using the registered request, then the state goes to S_RESP.
- In S_RESP: `rvalid_o`=1 for exactly one cycle, then the state goes to S_IDLE.
- Address decode:
  - In range means `BASE_ADDR ≤ addr < BASE_ADDR + 4*DEPTH`.
  - Word index = `(addr - BASE_ADDR) >> 2`. `addr[1:0]` is ignored.
- Read, in range: `rdata_o` = full stored word, regardless of `be`. `err_o`=0.
- Write, in range: each byte lane `k` with `be[k]`=1 is updated from `wdata[8k+7:8k]`. Other lanes are unchanged. `be`=0 performs no update and reports no error. `err_o`=0.
- Out of range (read or write): memory is unchanged, `rdata_o`=0, `err_o`=1.
- Write response: `rdata_o`=0.
- Memory contents are not reset and are undefined after power-up.

## Timing
- Reset values: `gnt_o`=0 (while `req_i`=0), `rvalid_o`=0, `rdata_o`=0, `err_o`=0.
- Outputs `rvalid_o`, `rdata_o` and `err_o` are registered. When `rvalid_o`=0, both `rdata_o` and `err_o` are 0.
- Latency: for a grant in cycle T, `rvalid_o` is high in cycle T+1+`WAIT_CYCLES`.
- Throughput: the next grant is possible in cycle T+2+`WAIT_CYCLES`. With `WAIT_CYCLES`=0, back-to-back requests are granted every 2 cycles.
- The request inputs are sampled only at the grant edge. Changes to them after grant have no effect.
- `req_i` dropping during S_WAIT or S_RESP has no effect. The granted transaction still completes.
- A write followed by a read of the same word returns the new data. The write completes before the read is granted.
- Reset mid-transaction:
  - The state returns to S_IDLE and no `rvalid_o` is issued.
  - A write whose execute edge has not yet occurred is not committed.

## Test plan
- `WAIT_CYCLES`=0: write `addr`=0x2000_0010, `be`=4'hF, `wdata`=0xDEAD_BEEF, then read 0x2000_0010. Required response:
  - Grant in cycle T, `rvalid_o` in cycle T+1.
  - Read `rdata_o`=0xDEAD_BEEF, `err_o`=0.
- Byte enables: with word = 0xDEAD_BEEF, write `be`=4'b0100, `wdata`=0x0055_0000, then read. Required response: `rdata_o`=0xDE55_BEEF. A write with `be`=0 leaves the word unchanged, with `err_o`=0.
- `WAIT_CYCLES`=3: read granted in cycle T. Required response:
  - `rvalid_o` only in cycle T+4.
  - `gnt_o`=0 through T+4, even with `req_i` held high.
  - Next grant in T+5.
- Out of range: write then read at 0x1FFF_FFFC and at `BASE_ADDR+4*DEPTH`. Required response:
  - Each gives `rvalid_o` with `err_o`=1 and `rdata_o`=0.
  - Word 0 and word `DEPTH-1` are unchanged afterwards.
- Reset mid-operation: with `WAIT_CYCLES`=3, issue a write to word 5. Assert `rst_n`=0 in cycle T+2. Required response:
  - No `rvalid_o`.
  - After reset, a read of word 5 returns its pre-write value.
- Sampling after grant: change `addr_i`/`wdata_i` in the cycle after grant (`WAIT_CYCLES`=2). Required response: only the originally presented address and data are written.
